// File: rtl/axi_burst_pkg.sv
// Shared widths, bus field layouts, FSM encodings and response codes for the
// AXI burst master and its beat counter.
package axi_burst_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int LEN_W   = 4;
    localparam int ID_W    = 4;

    localparam int CMD_W   = ADDR_W + LEN_W + ID_W;
    localparam int R_W     = ID_W + DATA_W + 3;
    localparam int RD_W    = DATA_W + 4;
    localparam int W_W     = DATA_W + 1;
    localparam int B_W     = ID_W + 2;
    localparam int WDONE_W = 3;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [ID_W-1:0]   id;
    } cmd_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } r_beat_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_rsp_t;

endpackage

// File: rtl/axi_burst_master_if.sv
// Bundle of the user command/data ports and the AXI read/write channels
// seen by the burst master (master) and by its environment (slave).
interface axi_burst_master_if;
    import axi_burst_pkg::*;

    logic               rcmd_valid;
    logic               rcmd_ready;
    logic [CMD_W-1:0]   rcmd;
    logic               ARVALID;
    logic               ARREADY;
    logic [CMD_W-1:0]   AR;
    logic               RVALID;
    logic               RREADY;
    logic [R_W-1:0]     R;
    logic               rd_valid;
    logic [RD_W-1:0]    rd;

    logic               wcmd_valid;
    logic               wcmd_ready;
    logic [CMD_W-1:0]   wcmd;
    logic               wd_valid;
    logic               wd_ready;
    logic [DATA_W-1:0]  wd_data;
    logic               AWVALID;
    logic               AWREADY;
    logic [CMD_W-1:0]   AW;
    logic               WVALID;
    logic               WREADY;
    logic [W_W-1:0]     W;
    logic               BVALID;
    logic               BREADY;
    logic [B_W-1:0]     B;
    logic               wdone_valid;
    logic [WDONE_W-1:0] wdone;

    modport master (
        input  rcmd_valid, output rcmd_ready, input  rcmd,
        output ARVALID,    input  ARREADY,    output AR,
        input  RVALID,     output RREADY,     input  R,
        output rd_valid,   output rd,
        input  wcmd_valid, output wcmd_ready, input  wcmd,
        input  wd_valid,   output wd_ready,   input  wd_data,
        output AWVALID,    input  AWREADY,    output AW,
        output WVALID,     input  WREADY,     output W,
        input  BVALID,     output BREADY,     input  B,
        output wdone_valid, output wdone
    );

    modport slave (
        output rcmd_valid, input  rcmd_ready, output rcmd,
        input  ARVALID,    output ARREADY,    input  AR,
        output RVALID,     input  RREADY,     output R,
        input  rd_valid,   input  rd,
        output wcmd_valid, input  wcmd_ready, output wcmd,
        output wd_valid,   input  wd_ready,   output wd_data,
        input  AWVALID,    output AWREADY,    input  AW,
        input  WVALID,     output WREADY,     input  W,
        output BVALID,     input  BREADY,     output B,
        input  wdone_valid, input  wdone
    );

endinterface

// File: rtl/burst_beat_counter.sv
// Per-channel beat counter: cleared at command acceptance, advanced per beat,
// flags when the current beat index equals the burst length field.
module burst_beat_counter
    import axi_burst_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    input  logic [LEN_W-1:0] len,
    output logic             at_len
);

    logic [LEN_W-1:0] count_r;

    // Beat index register; clear has priority over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {LEN_W{1'b0}};
        end else if (clear) begin
            count_r <= {LEN_W{1'b0}};
        end else if (inc) begin
            count_r <= count_r + LEN_W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign at_len = (count_r == len);

endmodule

// File: rtl/axi_burst_master.sv
// AXI burst master: independent read and write FSMs turning user commands into
// AR/R and AW/W/B bursts, with per-beat read delivery and write completion.
module axi_burst_master
    import axi_burst_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    axi_burst_master_if.master bus
);

    rd_state_t         rd_state_r;
    logic              rcmd_ready_r;
    logic              arvalid_r;
    cmd_t              ar_r;
    logic              rready_r;
    logic              rd_valid_r;
    logic [RD_W-1:0]   rd_r;

    r_beat_t           r_beat_s;
    logic              rcmd_hs_s;
    logic              ar_hs_s;
    logic              r_hs_s;
    logic              r_at_len_s;
    logic              r_err_s;

    wr_state_t         wr_state_r;
    logic              wcmd_ready_r;
    logic              awvalid_r;
    cmd_t              aw_r;
    logic              wvalid_r;
    logic [DATA_W-1:0] w_data_r;
    logic              w_last_r;
    logic              bready_r;
    logic              wdone_valid_r;
    logic [WDONE_W-1:0] wdone_r;

    b_rsp_t            b_s;
    logic              wcmd_hs_s;
    logic              aw_hs_s;
    logic              w_hs_s;
    logic              wd_ready_s;
    logic              wd_hs_s;
    logic              b_hs_s;
    logic              w_at_len_s;

    assign r_beat_s  = bus.R;
    assign rcmd_hs_s = bus.rcmd_valid & rcmd_ready_r;
    assign ar_hs_s   = arvalid_r & bus.ARREADY;
    assign r_hs_s    = bus.RVALID & rready_r;

    // A beat is in error if its ID is foreign or RLAST disagrees with the count.
    assign r_err_s = (r_beat_s.id != ar_r.id) | (r_beat_s.last != r_at_len_s);

    burst_beat_counter u_rd_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (rcmd_hs_s),
        .inc    (r_hs_s),
        .len    (ar_r.len),
        .at_len (r_at_len_s)
    );

    // Read FSM with registered AR, RREADY and read-beat delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_r   <= R_IDLE;
            rcmd_ready_r <= 1'b1;
            arvalid_r    <= 1'b0;
            ar_r         <= {CMD_W{1'b0}};
            rready_r     <= 1'b0;
            rd_valid_r   <= 1'b0;
            rd_r         <= {RD_W{1'b0}};
        end else begin
            rd_valid_r <= 1'b0;
            case (rd_state_r)
                R_IDLE: begin
                    if (rcmd_hs_s) begin
                        ar_r         <= bus.rcmd;
                        arvalid_r    <= 1'b1;
                        rcmd_ready_r <= 1'b0;
                        rd_state_r   <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (ar_hs_s) begin
                        arvalid_r  <= 1'b0;
                        rready_r   <= 1'b1;
                        rd_state_r <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs_s) begin
                        rd_valid_r <= 1'b1;
                        rd_r       <= {r_beat_s.data, r_beat_s.resp, r_beat_s.last, r_err_s};
                        // Only RLAST ends the burst, even after a length mismatch.
                        if (r_beat_s.last) begin
                            rready_r     <= 1'b0;
                            rcmd_ready_r <= 1'b1;
                            rd_state_r   <= R_IDLE;
                        end
                    end
                end
                default: begin
                    rd_state_r   <= R_IDLE;
                    rcmd_ready_r <= 1'b1;
                    arvalid_r    <= 1'b0;
                    rready_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rcmd_ready = rcmd_ready_r;
    assign bus.ARVALID    = arvalid_r;
    assign bus.AR         = ar_r;
    assign bus.RREADY     = rready_r;
    assign bus.rd_valid   = rd_valid_r;
    assign bus.rd         = rd_r;

    assign b_s       = bus.B;
    assign wcmd_hs_s = bus.wcmd_valid & wcmd_ready_r;
    assign aw_hs_s   = awvalid_r & bus.AWREADY;
    assign w_hs_s    = wvalid_r & bus.WREADY;
    assign b_hs_s    = bus.BVALID & bready_r;
    assign wd_hs_s   = bus.wd_valid & wd_ready_s;

    // The output slot refills when empty or draining; once WLAST is loaded no more beats are taken.
    assign wd_ready_s = (wr_state_r == W_DATA) & ~(wvalid_r & w_last_r) & (~wvalid_r | bus.WREADY);

    burst_beat_counter u_wr_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (wcmd_hs_s),
        .inc    (wd_hs_s),
        .len    (aw_r.len),
        .at_len (w_at_len_s)
    );

    // Write FSM with registered AW, single W output slot, BREADY and completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_r    <= W_IDLE;
            wcmd_ready_r  <= 1'b1;
            awvalid_r     <= 1'b0;
            aw_r          <= {CMD_W{1'b0}};
            wvalid_r      <= 1'b0;
            w_data_r      <= {DATA_W{1'b0}};
            w_last_r      <= 1'b0;
            bready_r      <= 1'b0;
            wdone_valid_r <= 1'b0;
            wdone_r       <= {WDONE_W{1'b0}};
        end else begin
            wdone_valid_r <= 1'b0;
            case (wr_state_r)
                W_IDLE: begin
                    if (wcmd_hs_s) begin
                        aw_r         <= bus.wcmd;
                        awvalid_r    <= 1'b1;
                        wcmd_ready_r <= 1'b0;
                        wr_state_r   <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (aw_hs_s) begin
                        awvalid_r  <= 1'b0;
                        wr_state_r <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wd_hs_s) begin
                        w_data_r <= bus.wd_data;
                        w_last_r <= w_at_len_s;
                        wvalid_r <= 1'b1;
                    end else if (w_hs_s) begin
                        wvalid_r <= 1'b0;
                        if (w_last_r) begin
                            bready_r   <= 1'b1;
                            wr_state_r <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_hs_s) begin
                        bready_r      <= 1'b0;
                        wdone_valid_r <= 1'b1;
                        wdone_r       <= {b_s.resp, (b_s.id != aw_r.id)};
                        wcmd_ready_r  <= 1'b1;
                        wr_state_r    <= W_IDLE;
                    end
                end
                default: begin
                    wr_state_r   <= W_IDLE;
                    wcmd_ready_r <= 1'b1;
                    awvalid_r    <= 1'b0;
                    wvalid_r     <= 1'b0;
                    bready_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wcmd_ready  = wcmd_ready_r;
    assign bus.wd_ready    = wd_ready_s;
    assign bus.AWVALID     = awvalid_r;
    assign bus.AW          = aw_r;
    assign bus.WVALID      = wvalid_r;
    assign bus.W           = {w_data_r, w_last_r};
    assign bus.BREADY      = bready_r;
    assign bus.wdone_valid = wdone_valid_r;
    assign bus.wdone       = wdone_r;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed and randomized bench for axi_burst_master; expected beats and
// completions are derived from the burst parameters chosen by the bench.
module tb_axi_burst_master;
    import axi_burst_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    axi_burst_master_if bus();

    axi_burst_master dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.rcmd_valid = 1'b0; bus.rcmd = '0; bus.ARREADY = 1'b0;
        bus.RVALID = 1'b0;     bus.R = '0;
        bus.wcmd_valid = 1'b0; bus.wcmd = '0; bus.wd_valid = 1'b0; bus.wd_data = '0;
        bus.AWREADY = 1'b0;    bus.WREADY = 1'b0; bus.BVALID = 1'b0; bus.B = '0;
    endtask

    task automatic check_reset_state(input string ph);
        chk({ph, "_arvalid"}, 32'(bus.ARVALID), 32'd0);
        chk({ph, "_ar"}, 32'(bus.AR), 32'd0);
        chk({ph, "_rready"}, 32'(bus.RREADY), 32'd0);
        chk({ph, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
        chk({ph, "_rd"}, 32'(bus.rd), 32'd0);
        chk({ph, "_awvalid"}, 32'(bus.AWVALID), 32'd0);
        chk({ph, "_aw"}, 32'(bus.AW), 32'd0);
        chk({ph, "_wvalid"}, 32'(bus.WVALID), 32'd0);
        chk({ph, "_w"}, 32'(bus.W), 32'd0);
        chk({ph, "_bready"}, 32'(bus.BREADY), 32'd0);
        chk({ph, "_wdone_valid"}, 32'(bus.wdone_valid), 32'd0);
        chk({ph, "_wdone"}, 32'(bus.wdone), 32'd0);
        chk({ph, "_wd_ready"}, 32'(bus.wd_ready), 32'd0);
        chk({ph, "_rcmd_ready"}, 32'(bus.rcmd_ready), 32'd1);
        chk({ph, "_wcmd_ready"}, 32'(bus.wcmd_ready), 32'd1);
    endtask

    // Read burst: RLAST sent on beat last_idx; expected err from ID and length rules.
    task automatic read_burst(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                              input logic [ID_W-1:0] id, input int ar_wait,
                              input int last_idx, input logic [ID_W-1:0] rid, input bit gaps);
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] d;
        logic [1:0]        rr;
        logic              lst;
        logic              e;
        cmd = {a, l, id};
        bus.rcmd = cmd; bus.rcmd_valid = 1'b1;
        #1 chk("rcmd_ready_idle", 32'(bus.rcmd_ready), 32'd1);
        @(negedge clk);
        bus.rcmd_valid = 1'b0;
        chk("arvalid_rise", 32'(bus.ARVALID), 32'd1);
        chk("ar_bus", 32'(bus.AR), 32'(cmd));
        chk("rcmd_ready_busy", 32'(bus.rcmd_ready), 32'd0);
        for (int k = 0; k < ar_wait; k++) begin
            bus.R = R_W'($urandom); bus.RVALID = 1'b1;
            @(negedge clk);
            chk("ar_hold", 32'(bus.ARVALID), 32'd1);
            chk("ar_stable", 32'(bus.AR), 32'(cmd));
            chk("rready_in_addr", 32'(bus.RREADY), 32'd0);
            chk("stray_r_ignored", 32'(bus.rd_valid), 32'd0);
        end
        bus.RVALID = 1'b0;
        bus.ARREADY = 1'b1;
        @(negedge clk);
        bus.ARREADY = 1'b0;
        chk("ar_drop", 32'(bus.ARVALID), 32'd0);
        chk("rready_data", 32'(bus.RREADY), 32'd1);
        for (int i = 0; i <= last_idx; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    chk("rd_gap", 32'(bus.rd_valid), 32'd0);
                end
            end
            d   = DATA_W'($urandom);
            rr  = ($urandom_range(0, 1) == 0) ? RESP_OKAY : RESP_SLVERR;
            lst = (i == last_idx);
            bus.R = {rid, d, rr, lst}; bus.RVALID = 1'b1;
            @(negedge clk);
            bus.RVALID = 1'b0;
            e = (rid != id) || (lst != (i == int'(l)));
            chk("rd_valid", 32'(bus.rd_valid), 32'd1);
            chk("rd", 32'(bus.rd), 32'({d, rr, lst, e}));
        end
        chk("rready_done", 32'(bus.RREADY), 32'd0);
        chk("rcmd_ready_back", 32'(bus.rcmd_ready), 32'd1);
    endtask

    // Write burst: mode 0 random WREADY, 1 toggling, 2 always ready.
    task automatic write_burst(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                               input logic [ID_W-1:0] id, input int aw_wait, input int mode,
                               input bit gaps, input logic [ID_W-1:0] bid, input logic [1:0] bresp);
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] data [16];
        logic [W_W-1:0]    wobs;
        logic              wv;
        logic              wr;
        int                si;
        int                ki;
        int                cyc;
        for (int i = 0; i < 16; i++) data[i] = DATA_W'($urandom);
        cmd = {a, l, id};
        bus.wcmd = cmd; bus.wcmd_valid = 1'b1;
        #1 chk("wcmd_ready_idle", 32'(bus.wcmd_ready), 32'd1);
        @(negedge clk);
        bus.wcmd_valid = 1'b0;
        chk("awvalid_rise", 32'(bus.AWVALID), 32'd1);
        chk("aw_bus", 32'(bus.AW), 32'(cmd));
        chk("wcmd_ready_busy", 32'(bus.wcmd_ready), 32'd0);
        for (int k = 0; k < aw_wait; k++) begin
            bus.B = B_W'($urandom); bus.BVALID = 1'b1;
            @(negedge clk);
            chk("aw_hold", 32'(bus.AWVALID), 32'd1);
            chk("aw_stable", 32'(bus.AW), 32'(cmd));
            chk("bready_early", 32'(bus.BREADY), 32'd0);
            chk("stray_b_ignored", 32'(bus.wdone_valid), 32'd0);
        end
        bus.BVALID = 1'b0;
        bus.AWREADY = 1'b1;
        @(negedge clk);
        bus.AWREADY = 1'b0;
        chk("aw_drop", 32'(bus.AWVALID), 32'd0);
        si = 0; ki = 0; cyc = 0; wr = 1'b0;
        while (ki <= int'(l) && cyc < 300) begin
            case (mode)
                0:       wr = 1'($urandom_range(0, 1));
                1:       wr = ~wr;
                default: wr = 1'b1;
            endcase
            bus.WREADY   = wr;
            bus.wd_valid = (si <= int'(l)) && (!gaps || $urandom_range(0, 3) != 0);
            bus.wd_data  = (si <= int'(l)) ? data[si[3:0]] : '0;
            #1;
            wv   = bus.WVALID;
            wobs = bus.W;
            chk("wd_ready_rule", 32'(bus.wd_ready), 32'(!(wv && wobs[0]) && (!wv || wr)));
            if (wv && wr) begin
                chk("w_beat", 32'(wobs), 32'({data[ki[3:0]], (ki == int'(l))}));
                ki++;
            end
            if (bus.wd_valid && bus.wd_ready) si++;
            cyc++;
            @(negedge clk);
        end
        bus.WREADY = 1'b0; bus.wd_valid = 1'b0;
        chk("w_beat_count", 32'(ki), 32'(int'(l) + 1));
        chk("wd_taken", 32'(si), 32'(int'(l) + 1));
        chk("wvalid_after_last", 32'(bus.WVALID), 32'd0);
        chk("bready_resp", 32'(bus.BREADY), 32'd1);
        bus.B = {bid, bresp}; bus.BVALID = 1'b1;
        @(negedge clk);
        bus.BVALID = 1'b0;
        chk("wdone_valid", 32'(bus.wdone_valid), 32'd1);
        chk("wdone", 32'(bus.wdone), 32'({bresp, (bid != id)}));
        chk("bready_done", 32'(bus.BREADY), 32'd0);
        chk("wcmd_ready_back", 32'(bus.wcmd_ready), 32'd1);
        @(negedge clk);
        chk("wdone_pulse_end", 32'(bus.wdone_valid), 32'd0);
    endtask

    logic [LEN_W-1:0] rl;
    logic [LEN_W-1:0] wl;
    logic [ID_W-1:0]  rid;
    logic [ID_W-1:0]  wid;
    logic [ID_W-1:0]  rid_beat;
    logic [ID_W-1:0]  bid;
    int               ridx;
    logic [DATA_W-1:0] a1;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        check_reset_state("por");
        rst = 1'b0;
        @(negedge clk);

        // Four-beat read, ARREADY after two cycles, clean RLAST.
        read_burst(8'h40, 4'd3, 4'd5, 2, 3, 4'd5, 1'b0);
        // Early RLAST on a two-beat read flags err and still ends the burst.
        read_burst(8'h22, 4'd1, 4'd2, 0, 0, 4'd2, 1'b0);
        // Three-beat write with WREADY toggling every cycle.
        write_burst(8'h10, 4'd2, 4'd3, 1, 1, 1'b0, 4'd3, RESP_OKAY);
        // Concurrent read and write, BID mismatch on the write.
        fork
            read_burst(8'h80, 4'd2, 4'd9, 1, 2, 4'd9, 1'b0);
            write_burst(8'h10, 4'd2, 4'd3, 0, 2, 1'b0, 4'd7, RESP_OKAY);
        join
        // Length extremes: single beat and 16 beats.
        read_burst(8'h01, 4'd0, 4'd1, 0, 0, 4'd1, 1'b0);
        write_burst(8'h02, 4'd0, 4'd4, 0, 2, 1'b0, 4'd4, RESP_SLVERR);
        read_burst(8'hF0, 4'd15, 4'd6, 1, 15, 4'd6, 1'b1);
        write_burst(8'hE0, 4'd15, 4'd8, 1, 0, 1'b1, 4'd8, RESP_OKAY);

        for (int it = 0; it < 8; it++) begin
            rl  = LEN_W'($urandom_range(0, 15));
            wl  = LEN_W'($urandom_range(0, 15));
            rid = ID_W'($urandom);
            wid = ID_W'($urandom);
            ridx     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(rl))) : int'(rl);
            rid_beat = ($urandom_range(0, 3) == 0) ? rid + 4'd1 : rid;
            bid      = ($urandom_range(0, 3) == 0) ? wid ^ 4'd5 : wid;
            fork
                read_burst(ADDR_W'($urandom), rl, rid, int'($urandom_range(0, 3)), ridx, rid_beat, 1'b1);
                write_burst(ADDR_W'($urandom), wl, wid, int'($urandom_range(0, 3)), 0, 1'b1, bid,
                            ($urandom_range(0, 1) == 0) ? RESP_OKAY : RESP_SLVERR);
            join
        end

        // Reset during write beat 1 with a read parked in its address phase.
        bus.wcmd = {8'h30, 4'd3, 4'd2}; bus.wcmd_valid = 1'b1;
        bus.rcmd = {8'h50, 4'd1, 4'd6}; bus.rcmd_valid = 1'b1;
        @(negedge clk);
        bus.wcmd_valid = 1'b0; bus.rcmd_valid = 1'b0;
        bus.AWREADY = 1'b1;
        @(negedge clk);
        bus.AWREADY = 1'b0;
        bus.wd_valid = 1'b1; bus.wd_data = 8'hA0; bus.WREADY = 1'b0;
        @(negedge clk);
        a1 = 8'hA1;
        bus.wd_data = a1; bus.WREADY = 1'b1;
        @(negedge clk);
        chk("mid_beat1_loaded", 32'(bus.W), 32'({a1, 1'b0}));
        rst = 1'b1;
        bus.wd_valid = 1'b0; bus.WREADY = 1'b0;
        @(negedge clk);
        check_reset_state("mid");
        rst = 1'b0;
        @(negedge clk);
        write_burst(8'h31, 4'd1, 4'd2, 0, 2, 1'b0, 4'd2, RESP_OKAY);
        read_burst(8'h51, 4'd1, 4'd6, 0, 1, 4'd6, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_burst_master.md
AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 ADDR_W, 8, address width.
REQ-002 DATA_W, 8, data beat width.
REQ-003 LEN_W, 4, burst length field width (len = beats-1, up to 2^LEN_W beats).
REQ-004 ID_W, 4, transaction ID width.
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 rcmd_valid  in  1  read command offered.
REQ-008 rcmd_ready  out  1  read command accepted.
REQ-009 rcmd  in  ADDR_W+LEN_W+ID_W  {addr, len, id}.
REQ-010 ARVALID  out  1  read address valid.
REQ-011 ARREADY  in  1  read address ready.
REQ-012 AR  out  ADDR_W+LEN_W+ID_W  {ARADDR, ARLEN, ARID}.
REQ-013 RVALID  in  1  read beat valid.
REQ-014 RREADY  out  1  read beat ready.
REQ-015 R  in  ID_W+DATA_W+3  {RID, RDATA, RRESP[1:0], RLAST}.
REQ-016 rd_valid  out  1  one-cycle pulse per delivered read beat.
REQ-017 rd  out  DATA_W+4  {data, resp[1:0], last, err}.
REQ-018 wcmd_valid  in  1  write command offered.
REQ-019 wcmd_ready  out  1  write command accepted.
REQ-020 wcmd  in  ADDR_W+LEN_W+ID_W  {addr, len, id}.
REQ-021 wd_valid  in  1  write data beat offered.
REQ-022 wd_ready  out  1  write data beat accepted.
REQ-023 wd_data  in  DATA_W  write data beat.
REQ-024 AWVALID  out  1  write address valid.
REQ-025 AWREADY  in  1  write address ready.
REQ-026 AW  out  ADDR_W+LEN_W+ID_W  {AWADDR, AWLEN, AWID}.
REQ-027 WVALID  out  1  write beat valid.
REQ-028 WREADY  in  1  write beat ready.
REQ-029 W  out  DATA_W+1  {WDATA, WLAST}.
REQ-030 BVALID  in  1  write response valid.
REQ-031 BREADY  out  1  write response ready.
REQ-032 B  in  ID_W+2  {BID, BRESP}.
REQ-033 wdone_valid  out  1  one-cycle pulse at burst completion.
REQ-034 wdone  out  3  {resp[1:0], err}.

Function
REQ-035 Read FSM SHALL be R_IDLE->R_ADDR (rcmd handshake)->R_DATA (ARVALID&ARREADY)->R_IDLE (RVALID&RREADY&RLAST); rcmd_ready=1 only in R_IDLE; ARVALID rises the cycle after command acceptance, with AR held stable until ARREADY; RREADY=1 only in R_DATA.
REQ-036 Each R handshake SHALL produce rd_valid plus registered rd exactly one cycle later; beat counter (LEN_W bits) counts from 0; err=1 when RID!=ARID, RLAST arrives with count!=len, or count==len arrives without RLAST; the burst continues until RLAST regardless.
REQ-037 Write FSM SHALL be W_IDLE->W_ADDR->W_DATA->W_RESP->W_IDLE; AW timing mirrors AR; W_DATA uses a single output register with wd_ready = !WVALID | WREADY; WLAST=1 on beat count==len; WVALID&WREADY&WLAST -> W_RESP.
REQ-038 In W_RESP, BREADY SHALL be 1; on BVALID, wdone_valid pulses the next cycle with wdone.resp=BRESP and err=(BID!=AWID).
REQ-039 Read and write FSMs SHALL be independent; simultaneous rcmd and wcmd SHALL both be accepted in the same cycle.
REQ-040 R beats offered outside R_DATA and B responses outside W_RESP SHALL be ignored (READY low); wd_valid gaps SHALL insert WVALID bubbles without counting a beat.
REQ-041 len=0 SHALL yield a single beat with last/WLAST=1; len=2^LEN_W-1 SHALL not wrap the counter before the last beat.

Reset
REQ-042 rst SHALL set both FSMs to IDLE, all outputs and buses to 0, and all counters to 0, discarding any in-flight burst, including mid-burst.

Structure
REQ-043 Package axi_burst_pkg SHALL hold read/write state encodings, RESP codes (OKAY=0, SLVERR=2), and field-width helpers.
REQ-044 One sub-module, burst_beat_counter (clear/inc/at_len), SHALL be instantiated once per channel.

Verification
REQ-045 rcmd{0x40,len 3,id 5}, ARREADY after 2 cycles, 4 R beats ID 5, RLAST on beat 3 -> 4 rd_valid pulses, last only on 4th, err=0.
REQ-046 Read len 1 with RLAST on beat 0 -> rd.err=1 on that beat; FSM returns to R_IDLE.
REQ-047 wcmd{0x10,len 2,id 3}, WREADY toggling every cycle -> 3 W beats in order, WLAST on 3rd, BID 3 BRESP 0 -> wdone={0,0}.
REQ-048 Simultaneous rcmd and wcmd, BID 7 mismatching AWID 3 -> both complete, wdone.err=1.
REQ-049 rst asserted during write beat 1 -> next cycle all outputs 0, wcmd_ready=1, rcmd_ready=1.
